// File: rtl/alu_rr_sched.sv
// Round-robin sharing of one ALU between two requesters.
// Latches the winner's operands, waits ALU_LAT edges, returns result with a done pulse.
module alu_rr_sched #(
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [31:0]      opa0,
   input  logic [31:0]      opb0,
   input  logic [31:0]      opa1,
   input  logic [31:0]      opb1,
   input  logic [2:0]       sel0,
   input  logic [2:0]       sel1,
   output logic             done0,
   output logic             done1,
   output logic [31:0]      rdata,
   output logic             rz,
   output logic             rc,
   output logic             rv,
   output logic             busy,
   output logic [31:0]      alu_opA,
   output logic [31:0]      alu_opB,
   output logic [2:0]       alu_sel,
   input  logic [31:0]      alu_res,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] WLOAD = 4'(ALU_LAT - 1);

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             gnt_q, gnt_d;
   logic [31:0]      opa_q, opa_d;
   logic [31:0]      opb_q, opb_d;
   logic [2:0]       sel_q, sel_d;
   logic [3:0]       wcnt_q, wcnt_d;
   logic [31:0]      res_q, res_d;
   logic             z_q, z_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic             win1;

   // On a tie the requester not served last wins.
   assign win1 = req1 & (~req0 | ~last_q);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sel_d   = sel_q;
      wcnt_d  = wcnt_q;
      res_d   = res_q;
      z_d     = z_q;
      c_d     = c_q;
      v_d     = v_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               gnt_d   = win1;
               opa_d   = win1 ? opa1 : opa0;
               opb_d   = win1 ? opb1 : opb0;
               sel_d   = win1 ? sel1 : sel0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wcnt_d  = WLOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (wcnt_q == 4'd0) begin
               res_d   = alu_res;
               z_d     = alu_z;
               c_d     = alu_c;
               v_d     = alu_v;
               state_d = DONE;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         DONE: begin
            if (gnt_q) cnt1_d = cnt1_q + CNT_W'(1);
            else       cnt0_d = cnt0_q + CNT_W'(1);
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sel_q   <= '0;
         wcnt_q  <= '0;
         res_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sel_q   <= sel_d;
         wcnt_q  <= wcnt_d;
         res_q   <= res_d;
         z_q     <= z_d;
         c_q     <= c_d;
         v_q     <= v_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign done0   = (state_q == DONE) & ~gnt_q;
   assign done1   = (state_q == DONE) & gnt_q;
   assign busy    = (state_q != IDLE);
   assign alu_opA = opa_q;
   assign alu_opB = opb_q;
   assign alu_sel = sel_q;
   assign rdata   = res_q;
   assign rz      = z_q;
   assign rc      = c_q;
   assign rv      = v_q;
   assign cnt0    = cnt0_q;
   assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench: one ALU_LAT=1/CNT_W=2 instance and one ALU_LAT=4 instance.
// Each instance drives a bench ALU model; the ALU_LAT=4 one is delayed by 4 edges.
module tb_alu_rr_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int both_a = 0;
   int both_b = 0;

   // instance A: ALU_LAT=1, CNT_W=2
   logic        a_rst_n, a_req0, a_req1;
   logic [31:0] a_opa0, a_opb0, a_opa1, a_opb1;
   logic [2:0]  a_sel0, a_sel1;
   logic        a_done0, a_done1, a_rz, a_rc, a_rv, a_busy;
   logic [31:0] a_rdata, a_opA, a_opB, a_res;
   logic [2:0]  a_sel;
   logic        a_z, a_c, a_v;
   logic [1:0]  a_cnt0, a_cnt1;

   // instance B: ALU_LAT=4, CNT_W=16
   logic        b_rst_n, b_req0, b_req1;
   logic [31:0] b_opa0, b_opb0, b_opa1, b_opb1;
   logic [2:0]  b_sel0, b_sel1;
   logic        b_done0, b_done1, b_rz, b_rc, b_rv, b_busy;
   logic [31:0] b_rdata, b_opA, b_opB, b_res;
   logic [2:0]  b_sel;
   logic        b_z, b_c, b_v;
   logic [15:0] b_cnt0, b_cnt1;

   function automatic logic [34:0] alu_f(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [2:0]  s);
      logic [32:0] w;
      logic        v;
      w = '0;
      v = 1'b0;
      case (s)
         3'b000: begin
            w = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (w[31] != a[31]);
         end
         3'b001: begin
            w = {1'b0, a} - {1'b0, b};
            v = (a[31] != b[31]) && (w[31] != a[31]);
         end
         3'b010: w = {1'b0, a & b};
         3'b011: w = {1'b0, a | b};
         3'b100: w = {1'b0, a ^ b};
         3'b101: w = {1'b0, a << b[4:0]};
         3'b110: w = {1'b0, a >> b[4:0]};
         default: w = {1'b0, b};
      endcase
      return {(w[31:0] == 32'd0), w[32], v, w[31:0]};
   endfunction

   assign {a_z, a_c, a_v, a_res} = alu_f(a_opA, a_opB, a_sel);

   logic [34:0] pipe_b [4];
   always_ff @(posedge clk) begin
      pipe_b[0] <= alu_f(b_opA, b_opB, b_sel);
      for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign {b_z, b_c, b_v, b_res} = pipe_b[3];

   alu_rr_sched #(.ALU_LAT(1), .CNT_W(2)) u_a (
      .clk(clk), .rst_n(a_rst_n),
      .req0(a_req0), .req1(a_req1),
      .opa0(a_opa0), .opb0(a_opb0), .opa1(a_opa1), .opb1(a_opb1),
      .sel0(a_sel0), .sel1(a_sel1),
      .done0(a_done0), .done1(a_done1),
      .rdata(a_rdata), .rz(a_rz), .rc(a_rc), .rv(a_rv), .busy(a_busy),
      .alu_opA(a_opA), .alu_opB(a_opB), .alu_sel(a_sel),
      .alu_res(a_res), .alu_z(a_z), .alu_c(a_c), .alu_v(a_v),
      .cnt0(a_cnt0), .cnt1(a_cnt1)
   );

   alu_rr_sched #(.ALU_LAT(4), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(b_rst_n),
      .req0(b_req0), .req1(b_req1),
      .opa0(b_opa0), .opb0(b_opb0), .opa1(b_opa1), .opb1(b_opb1),
      .sel0(b_sel0), .sel1(b_sel1),
      .done0(b_done0), .done1(b_done1),
      .rdata(b_rdata), .rz(b_rz), .rc(b_rc), .rv(b_rv), .busy(b_busy),
      .alu_opA(b_opA), .alu_opB(b_opB), .alu_sel(b_sel),
      .alu_res(b_res), .alu_z(b_z), .alu_c(b_c), .alu_v(b_v),
      .cnt0(b_cnt0), .cnt1(b_cnt1)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (a_done0 && a_done1) both_a++;
      if (b_done0 && b_done1) both_b++;
   endtask

   // Wait for a done pulse on instance A; who=-1 if the budget runs out.
   task automatic wait_done_a(output int who, output int n);
      who = -1;
      n = 0;
      while (who < 0 && n < 20) begin
         tick();
         n++;
         if (a_done0) who = 0;
         else if (a_done1) who = 1;
      end
      chk("wait_done_a", 64'(who >= 0), 64'd1);
   endtask

   task automatic reset_a();
      a_req0 = 1'b0;
      a_req1 = 1'b0;
      a_rst_n = 1'b0;
      tick();
      a_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int who, n, seen;
      int ord_exp[4];
      int wrap_exp[5];
      ord_exp  = '{0, 1, 0, 1};
      wrap_exp = '{1, 2, 3, 0, 1};

      a_rst_n = 1'b1; b_rst_n = 1'b1;
      a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
      a_opa0 = 0; a_opb0 = 0; a_opa1 = 0; a_opb1 = 0;
      b_opa0 = 0; b_opb0 = 0; b_opa1 = 0; b_opb1 = 0;
      a_sel0 = 0; a_sel1 = 0; b_sel0 = 0; b_sel1 = 0;
      #2;
      a_rst_n = 1'b0; b_rst_n = 1'b0;

      // reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         a_req0 = 1'($urandom); a_req1 = 1'($urandom);
         b_req0 = 1'($urandom); b_req1 = 1'($urandom);
         a_opa0 = $urandom; a_opb0 = $urandom;
         a_opa1 = $urandom; a_opb1 = $urandom;
         b_opa0 = $urandom; b_opb0 = $urandom;
         a_sel0 = 3'($urandom); a_sel1 = 3'($urandom);
         tick();
      end
      chk("rst_ctl_a", 64'({a_done0, a_done1, a_busy, a_rz, a_rc, a_rv,
                            a_sel, a_cnt0, a_cnt1}), 64'd0);
      chk("rst_data_a", 64'(a_opA | a_opB | a_rdata), 64'd0);
      chk("rst_ctl_b", 64'({b_done0, b_done1, b_busy, b_rz, b_rc, b_rv,
                            b_sel, b_cnt0, b_cnt1}), 64'd0);
      chk("rst_data_b", 64'(b_opA | b_opB | b_rdata), 64'd0);

      a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_a", 64'({a_done0, a_done1, a_busy, a_sel, a_cnt0, a_cnt1})
             | 64'(a_opA | a_opB | a_rdata), 64'd0);
      end

      // single op, ALU_LAT=1: 10 AND 0
      a_opa0 = 32'd10; a_opb0 = 32'd0; a_sel0 = 3'b010;
      a_req0 = 1'b1;
      seen = 0;
      tick();
      seen |= int'(a_done1);
      chk("single_opA", 64'(a_opA), 64'd10);
      chk("single_sel", 64'(a_sel), 64'd2);
      chk("single_busy", 64'(a_busy), 64'd1);
      tick();
      seen |= int'(a_done1);
      chk("single_early", 64'(a_done0), 64'd0);
      tick();
      seen |= int'(a_done1);
      chk("single_done0", 64'(a_done0), 64'd1);
      chk("single_res", 64'({a_rz, a_rc, a_rv, a_rdata}), {29'd0, 3'b100, 32'd0});
      a_req0 = 1'b0;
      tick();
      seen |= int'(a_done1);
      chk("single_done_pulse", 64'(a_done0), 64'd0);
      chk("single_cnt0", 64'(a_cnt0), 64'd1);
      chk("single_no_done1", 64'(seen), 64'd0);

      // tie fairness
      reset_a();
      a_opa1 = 32'd15; a_opb1 = 32'd7; a_sel1 = 3'b011;
      a_req0 = 1'b1; a_req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_done_a(who, n);
         if (k == 3) begin
            a_req0 = 1'b0; a_req1 = 1'b0;
         end
         chk($sformatf("tie_order%0d", k), 64'(who), 64'(ord_exp[k]));
         if (ord_exp[k] == 1)
            chk($sformatf("tie_res%0d", k), 64'({a_rz, a_rdata}), 64'd15);
         else
            chk($sformatf("tie_res%0d", k), 64'({a_rz, a_rdata}), 64'h1_0000_0000);
      end
      tick();
      chk("tie_cnt", 64'({a_cnt0, a_cnt1}), 64'b1010);

      // counter wrap, CNT_W=2
      reset_a();
      for (int k = 0; k < 5; k++) begin
         a_req0 = 1'b1;
         wait_done_a(who, n);
         a_req0 = 1'b0;
         tick();
         chk($sformatf("wrap_cnt%0d", k), 64'(a_cnt0), 64'(wrap_exp[k]));
      end

      // ALU_LAT=4: 100 + 23
      b_opa0 = 32'd100; b_opb0 = 32'd23; b_sel0 = 3'b000;
      b_req0 = 1'b1;
      seen = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         seen |= int'(b_done0 | b_done1);
      end
      chk("lat4_early", 64'(seen), 64'd0);
      tick();
      chk("lat4_done0", 64'(b_done0), 64'd1);
      chk("lat4_res", 64'({b_rz, b_rc, b_rv, b_rdata}), 64'd123);
      b_req0 = 1'b0;
      tick();
      chk("lat4_cnt0", 64'(b_cnt0), 64'd1);

      // carry out: FFFFFFFF + 1
      b_opa0 = 32'hFFFF_FFFF; b_opb0 = 32'd1;
      b_req0 = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      b_req0 = 1'b0;
      chk("carry_done", 64'(b_done0), 64'd1);
      chk("carry_res", 64'({b_rz, b_rc, b_rv, b_rdata}), {29'd0, 3'b110, 32'd0});

      // signed overflow: 7FFFFFFF + 1
      tick();
      b_opa0 = 32'h7FFF_FFFF;
      b_req0 = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      b_req0 = 1'b0;
      chk("ovf_done", 64'(b_done0), 64'd1);
      chk("ovf_res", 64'({b_rz, b_rc, b_rv, b_rdata}), {29'd0, 3'b001, 32'h8000_0000});

      // reset during WAIT
      tick();
      b_opa1 = 32'd5; b_opb1 = 32'd3; b_sel1 = 3'b001;
      b_req1 = 1'b1;
      tick(); tick(); tick();
      chk("midrst_busy", 64'(b_busy), 64'd1);
      b_rst_n = 1'b0;
      b_req1 = 1'b0;
      #1;
      chk("midrst_abort", 64'({b_busy, b_done0, b_done1}), 64'd0);
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen |= int'(b_done0 | b_done1);
      end
      b_rst_n = 1'b1;
      tick();
      seen |= int'(b_done0 | b_done1);
      chk("midrst_no_done", 64'(seen), 64'd0);
      chk("midrst_cnt", 64'({b_cnt0, b_cnt1}), 64'd0);

      b_req1 = 1'b1;
      seen = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         seen |= int'(b_done0 | b_done1);
      end
      chk("recov_early", 64'(seen), 64'd0);
      tick();
      b_req1 = 1'b0;
      chk("recov_done1", 64'({b_done0, b_done1}), 64'd1);
      chk("recov_res", 64'({b_rz, b_rc, b_rv, b_rdata}), 64'd2);
      tick();
      chk("recov_cnt1", 64'(b_cnt1), 64'd1);

      chk("never_both_a", 64'(both_a), 64'd0);
      chk("never_both_b", 64'(both_b), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
